mio_bus_responder: RTL

- Memory/IO responder at the far end of the CPU's MIO bus.
- Accepts word requests from the multi-cycle CPU: request strobe, write flag, address and write data.
- Decodes each address to one of three targets: internal word RAM, a GPIO output register, or read-only peripherals (switches, free-running counter).
- Returns read data and a one-cycle ready pulse after a programmable number of wait states.

---
 rtl/mio_pkg.sv | 20 ++
 rtl/mio_ram.sv | 24 ++
 rtl/mio_bus_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mio_pkg.sv
// Shared address map, FSM states and the latched request record for the MIO responder.
// Constant-only package; no logic, no latency, no flow control.
package mio_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] GPIO_ADDR = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR   = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // Word address only: the byte offset is tracked separately when faults are enabled.
  typedef struct packed {
    logic        wr;
    logic [29:0] waddr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mio_ram.sv
// Single-port word RAM: one write and one registered read per cycle at the same address.
// Read data appears the cycle after the address; no backpressure, always accepts.
module mio_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wr_dat,
  output logic [31:0]   rd_dat
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wr_dat;
    rd_dat_q <= mem_q[addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus far-end responder: RAM, GPIO register, switches and a free-running counter (MIO_BUS_ERR_EN adds bus_err).
// Latency: mio_ready pulses WAIT_CYCLES+2 cycles after the request edge; the CPU holds cpu_mio until then.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int GPIO_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] sw_in,
  output logic              bus_err
);

  localparam int         AW        = $clog2(RAM_DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdy_q, rdy_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [GPIO_W-1:0] sw_s1_q, sw_s2_q;

  logic              hit_ram, hit_gpio, hit_sw, hit_cnt, fault;
  logic [31:0]       rd_val, ram_rd;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;

  assign hit_ram  = (req_q.waddr[29:AW] == RAM_BASE[31:AW+2]);
  assign hit_gpio = (req_q.waddr == GPIO_ADDR[31:2]);
  assign hit_sw   = (req_q.waddr == SW_ADDR[31:2]);
  assign hit_cnt  = (req_q.waddr == CNT_ADDR[31:2]);

  // Live address in IDLE so a zero-wait access still gets its RAM word into ACK.
  assign ram_addr = (state_q == IDLE) ? addr[AW+1:2] : req_q.waddr[AW-1:0];
  assign ram_we   = (state_q == ACK) && req_q.wr && hit_ram && !fault;

  mio_ram #(.DEPTH(RAM_DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .addr   (ram_addr),
    .wr_dat (req_q.wdata),
    .rd_dat (ram_rd)
  );

  always_comb begin
    rd_val = '0;
    if (hit_ram)       rd_val = ram_rd;
    else if (hit_gpio) rd_val = 32'(gpio_q);
    else if (hit_sw)   rd_val = 32'(sw_s2_q);
    else if (hit_cnt)  rd_val = cnt_q;
    if (fault)         rd_val = ERR_RDATA;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q + 32'd1;
    rdy_d   = 1'b0;
    rdata_d = '0;
    gpio_d  = gpio_q;
    case (state_q)
      IDLE: begin
        if (cpu_mio) begin
          req_d   = '{wr: mem_w, waddr: addr[31:2], wdata: wdata};
          wcnt_d  = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        rdata_d = rd_val;
        if (req_q.wr && hit_gpio && !fault) gpio_d = req_q.wdata[GPIO_W-1:0];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      gpio_q  <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      gpio_q  <= gpio_d;
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end

`ifdef MIO_BUS_ERR_EN
  logic mis_q, mis_d, err_q, err_d;

  assign fault = !(hit_ram || hit_gpio || hit_sw || hit_cnt)
               || (req_q.wr && (hit_sw || hit_cnt)) || mis_q;

  always_comb begin
    mis_d = mis_q;
    err_d = 1'b0;
    if (state_q == IDLE && cpu_mio) mis_d = (addr[1:0] != 2'b00);
    if (state_q == ACK)             err_d = fault;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end

  assign bus_err = err_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];
  assign fault   = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign rdata     = rdata_q;
  assign mio_ready = rdy_q;
  assign gpio_out  = gpio_q;

endmodule
